core_axi_mem_port: RTL

//  Parametrised AXI4 master access unit; one instance per core bus (INST, DATA).

---
 rtl/core_axi_mem_port.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/core_axi_mem_port.sv
// core_axi_mem_port: AXI4 master access unit for one core bus (INST or DATA).
// Converts single CPU-side requests into AXI4 INCR read bursts or single-beat
// writes. Only one transaction is outstanding at a time.
// Optional feature macro: AXI_PORT_ERRCHK_EN (sticky ERR on SLVERR/DECERR and
// RLAST mismatch). With the macro undefined, ERR is tied low.
module core_axi_mem_port #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_BURST_LEN        = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    // CPU request side
    input  logic                              REQ_VALID,
    output logic                              REQ_READY,
    input  logic                              REQ_WE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     REQ_ADDR,
    input  logic [7:0]                        REQ_LEN,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     REQ_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   REQ_WSTRB,
    // CPU response side
    output logic                              RSP_VALID,
    input  logic                              RSP_READY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_DATA,
    output logic                              RSP_LAST,
    output logic                              BUSY,
    output logic                              ERR,
    // AXI read address channel
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARLOCK,
    output logic [3:0]                        M_AXI_ARCACHE,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic [3:0]                        M_AXI_ARQOS,
    output logic                              M_AXI_ARUSER,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    // AXI read data channel
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    // AXI write address channel
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic                              M_AXI_AWUSER,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    // AXI write data channel
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WUSER,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    // AXI write response channel
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam logic [7:0] MAX_LEN = 8'(C_BURST_LEN - 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_MASK = C_M_AXI_ADDR_WIDTH'((1 << LSB) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                    len_q;
    logic [7:0]                    cnt_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]             wstrb_q;
    logic                          aw_done_q;
    logic                          w_done_q;

    logic       last_beat;
    logic [7:0] len_cap;

    assign last_beat = (cnt_q == len_q);
    assign len_cap   = (REQ_LEN > MAX_LEN) ? MAX_LEN : REQ_LEN;

    // State register with synchronous active-low reset
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and handshake outputs, all decoded from the current state
    always_comb begin
        state_nxt     = state;
        REQ_READY     = 1'b0;
        RSP_VALID     = 1'b0;
        RSP_DATA      = '0;
        RSP_LAST      = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (state)
            IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) state_nxt = REQ_WE ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                M_AXI_RREADY = RSP_READY;
                RSP_VALID    = M_AXI_RVALID;
                RSP_DATA     = M_AXI_RDATA;
                RSP_LAST     = last_beat;
                if (M_AXI_RVALID && RSP_READY && last_beat) state_nxt = IDLE;
            end
            WR_REQ: begin
                M_AXI_AWVALID = !aw_done_q;
                M_AXI_WVALID  = !w_done_q;
                if ((aw_done_q || M_AXI_AWREADY) && (w_done_q || M_AXI_WREADY))
                    state_nxt = WR_RESP;
            end
            WR_RESP: begin
                M_AXI_BREADY = RSP_READY;
                RSP_VALID    = M_AXI_BVALID;
                RSP_LAST     = 1'b1;
                if (M_AXI_BVALID && RSP_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, beat counter and write-channel done flags
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        addr_q    <= REQ_ADDR & ~ADDR_MASK;
                        len_q     <= REQ_WE ? '0 : len_cap;
                        wdata_q   <= REQ_WDATA;
                        wstrb_q   <= REQ_WSTRB;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) cnt_q <= '0;
                end
                RD_DATA: begin
                    if (M_AXI_RVALID && RSP_READY) cnt_q <= cnt_q + 8'd1;
                end
                WR_REQ: begin
                    if (M_AXI_AWREADY) aw_done_q <= 1'b1;
                    if (M_AXI_WREADY)  w_done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef AXI_PORT_ERRCHK_EN
    logic err_q;
    logic unused_resp_lsb;
    assign unused_resp_lsb = ^{M_AXI_RRESP[0], M_AXI_BRESP[0]};

    // Sticky error: slave error responses and RLAST disagreeing with the beat count
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            err_q <= 1'b0;
        end else begin
            if (state == RD_DATA && M_AXI_RVALID && RSP_READY &&
                (M_AXI_RRESP[1] || (M_AXI_RLAST != last_beat)))
                err_q <= 1'b1;
            if (state == WR_RESP && M_AXI_BVALID && RSP_READY && M_AXI_BRESP[1])
                err_q <= 1'b1;
        end
    end
    assign ERR = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{M_AXI_RRESP, M_AXI_BRESP, M_AXI_RLAST};
    assign ERR = 1'b0;
`endif

    assign BUSY = (state != IDLE);

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = len_q;
    assign M_AXI_ARSIZE  = 3'(LSB);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARUSER  = 1'b0;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = '0;
    assign M_AXI_AWSIZE  = 3'(LSB);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWUSER  = 1'b0;

    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_WUSER   = 1'b0;

endmodule
